iir_seq: RTL
============

IIR_SEQ -- requirements
Module: iir_seq

Interface
REQ-001 Parameter N, default 24, total data word width, signed two's complement.
REQ-002 Parameter F, default 14, fractional bits of coefficients and data.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to process one new sample; sampled only in IDLE.
REQ-006 u_in  input  N  new input sample, captured on the cycle start is accepted.
REQ-007 muxS, muxC, muxZ  input  N each  coefficient, state and offset operands returned by the coefficient/operand mux.
REQ-008 controlS  output  3  coefficient select: 0 zero, 1 a1, 2 a2, 3 b0, 4 b1, 5 b2.
REQ-009 controlC  output  2  state select: 0 zero, 1 fk1, 2 fk2, 3 fk.
REQ-010 controlZ  output  2  offset select: 0 zero, 1 Uk, 2 yk.
REQ-011 Uk, fk, fk1, fk2, yk  output  N each  registered input sample, DF-II state f[k], f[k-1], f[k-2] and filter output.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse; yk is valid and stable from this cycle onward.

Function
REQ-014 FSM states, one cycle each: IDLE, F1, F2, FW, Y0, Y1, Y2, YW, DN.
REQ-015 Sequence: IDLE -(start)-> F1 -> F2 -> FW -> Y0 -> Y1 -> Y2 -> YW -> DN -> IDLE.
REQ-016 IDLE with start=1 shall load Uk<=u_in; start=0 leaves all registers unchanged.
REQ-017 Selects per state: F1 (S1,C1,Z1); F2 (S2,C2,Z0); Y0 (S3,C3,Z0); Y1 (S4,C1,Z0); Y2 (S5,C2,Z0); all other states (0,0,0).
REQ-018 Selects shall be Moore outputs decoded from the current state; muxS/muxC/muxZ are combinational and consumed in the same cycle.
REQ-019 Product p = (muxS*muxC) as a 2N-bit signed value, arithmetically shifted right by F (floor), per product.
REQ-020 Accumulator width N+2; F1 and Y0 shall load acc<=muxZ+p; F2, Y1 and Y2 shall load acc<=acc+p.
REQ-021 FW shall load fk<=sat(acc); YW shall load yk<=sat(acc), fk1<=fk, fk2<=fk1 simultaneously.
REQ-022 sat() shall clamp to [-2^(N-1), 2^(N-1)-1].
REQ-023 Coefficient sign convention: a1/a2 as delivered by muxS are already negated, so the block always adds.
REQ-024 done shall be high only in DN, exactly 8 rising edges after the edge that accepted start; busy shall be high in F1..YW.
REQ-025 start asserted while not in IDLE, including in DN, shall be ignored; there is no queueing.
REQ-026 start held high continuously shall yield one sample per 9 cycles.

Reset
REQ-027 reset low shall immediately force state IDLE, and Uk, fk, fk1, fk2, yk and acc to 0.
REQ-028 reset low shall immediately force busy=0, done=0 and all selects to 0, regardless of current state.
REQ-029 reset asserted mid-sequence shall abort the sample with no done pulse; the first start after reset release behaves as a fresh sample.

Verification (bench models the mux with F=14, a1=-26066, a2=-10841, b0=13323, b1=26640, b2=13323, sign-extended)
REQ-030 Reset: pulse reset low mid-F2 -> all outputs 0 immediately, state IDLE, no done pulse.
REQ-031 Impulse, sample 1: from reset, start with u_in=16384 -> fk=16384, yk=13323, done 8 cycles after start, busy high for 7 cycles.
REQ-032 Impulse, sample 2: start with u_in=0 -> fk=-26066, fk1=16384, fk2=0 before YW, yk=5443 (-21197+26640) at done.
REQ-033 Saturation: Uk=8388607 and bench forces b0=32767 with fk1=fk2=0 -> yk=8388607; with Uk=-8388608 -> yk=-8388608.
REQ-034 Busy rejection: second start pulses in F2 and in DN -> ignored, exactly one done, state registers updated once.
REQ-035 Throughput: start held high for 3 samples -> done pulses at cycles 8, 17 and 26; select sequence matches REQ-017 each time.

Source files
------------

// File: rtl/iir_seq.sv
// Sequential direct-form-II biquad: one shared multiplier, operands are
// fetched through an external coefficient/state/offset mux, and each sample
// is processed in a fixed nine-cycle schedule.
module iir_seq #(
  parameter int N = 24,
  parameter int F = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [N-1:0] u_in,
  input  logic signed [N-1:0] muxS,
  input  logic signed [N-1:0] muxC,
  input  logic signed [N-1:0] muxZ,
  output logic [2:0]          controlS,
  output logic [1:0]          controlC,
  output logic [1:0]          controlZ,
  output logic signed [N-1:0] Uk,
  output logic signed [N-1:0] fk,
  output logic signed [N-1:0] fk1,
  output logic signed [N-1:0] fk2,
  output logic signed [N-1:0] yk,
  output logic                busy,
  output logic                done
);

  typedef enum logic [3:0] {
    IDLE, F1, F2, FW, Y0, Y1, Y2, YW, DN
  } state_t;

  // Clamp limits expressed at accumulator width so the compare stays signed.
  localparam logic signed [N+1:0] SAT_MAX = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [N+1:0] SAT_MIN = {3'b111, {(N-1){1'b0}}};

  state_t state, state_next;

  logic signed [2*N-1:0] prod_full;
  logic signed [N+1:0]   p;
  logic signed [N+1:0]   z_ext;
  logic signed [N+1:0]   acc;

  function automatic logic signed [N-1:0] sat(input logic signed [N+1:0] v);
    if (v > SAT_MAX)
      return SAT_MAX[N-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[N-1:0];
    else
      return v[N-1:0];
  endfunction

  // Full-precision product, floored by F, kept at accumulator width.
  assign prod_full = $signed({{N{muxS[N-1]}}, muxS}) * $signed({{N{muxC[N-1]}}, muxC});
  assign p         = (N+2)'(prod_full >>> F);
  assign z_ext     = {{2{muxZ[N-1]}}, muxZ};

  // State register; reset drops straight back to IDLE, aborting any sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state plus Moore decode of the operand selects, busy and done.
  always_comb begin
    state_next = state;
    controlS   = 3'd0;
    controlC   = 2'd0;
    controlZ   = 2'd0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = F1;
      end
      F1: begin
        state_next = F2;
        controlS   = 3'd1;
        controlC   = 2'd1;
        controlZ   = 2'd1;
        busy       = 1'b1;
      end
      F2: begin
        state_next = FW;
        controlS   = 3'd2;
        controlC   = 2'd2;
        busy       = 1'b1;
      end
      FW: begin
        state_next = Y0;
        busy       = 1'b1;
      end
      Y0: begin
        state_next = Y1;
        controlS   = 3'd3;
        controlC   = 2'd3;
        busy       = 1'b1;
      end
      Y1: begin
        state_next = Y2;
        controlS   = 3'd4;
        controlC   = 2'd1;
        busy       = 1'b1;
      end
      Y2: begin
        state_next = YW;
        controlS   = 3'd5;
        controlC   = 2'd2;
        busy       = 1'b1;
      end
      YW: begin
        state_next = DN;
        busy       = 1'b1;
      end
      DN: begin
        state_next = IDLE;
        done       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture the sample, accumulate products, then commit f[k] and
  // y[k]; the delay line shifts together with the output write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Uk  <= '0;
      fk  <= '0;
      fk1 <= '0;
      fk2 <= '0;
      yk  <= '0;
      acc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start)
            Uk <= u_in;
        end
        F1, Y0:     acc <= z_ext + p;
        F2, Y1, Y2: acc <= acc + p;
        FW:         fk  <= sat(acc);
        YW: begin
          yk  <= sat(acc);
          fk1 <= fk;
          fk2 <= fk1;
        end
        default: ;
      endcase
    end
  end

endmodule
